fifo_uart_tx: RTL and testbench

Read-side consumer for the 8-deep byte FIFO on the Arty Z7 design. The block pops one byte at a time through the FIFO's read port (`rd_en`/`empty`/`data_out`) and serializes it as an 8N1 UART frame, LSB first, on a single TX line. It sits between the FIFO and the board's USB-UART bridge pin and is the sole reader of the FIFO.

---
 rtl/fifo_uart_tx.sv | 109 ++++++++++
 tb/tb_fifo_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the FIFO and sends each as an 8N1 UART frame
// Sole FIFO reader: one pop per frame, LSB first, registered tx pin.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [2:0]    bit_idx_q;
    logic [BW-1:0] baud_q;
    logic          tx_q;
    logic          done_q;
    logic          baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (enable && !fifo_empty) state_q <= POP;
                end
                POP: state_q <= LOAD;
                // FIFO read data is valid now, one cycle after the pop edge
                LOAD: begin
                    shreg_q   <= fifo_data;
                    tx_q      <= 1'b0;
                    bit_idx_q <= 3'd0;
                    baud_q    <= '0;
                    state_q   <= START;
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            tx_q      <= shreg_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign byte_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx with CLKS_PER_BIT=4
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, pushes come from the stimulus process
    logic [7:0] fifo_q[$];
    int wr_total = 0;
    int rd_total = 0;
    int over_read = 0;
    assign fifo_empty = (wr_total == rd_total);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) over_read <= over_read + 1;
            else begin
                fifo_data <= fifo_q.pop_front();
                rd_total  <= rd_total + 1;
            end
        end
    end

    int cyc = 0;
    int rd_count = 0;
    int done_count = 0;
    int last_rd_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_count    <= rd_count + 1;
            last_rd_cyc <= cyc;
        end
        if (byte_done === 1'b1) done_count <= done_count + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        wr_total++;
    endtask

    // Waits for a start bit, records 10 bits (bit i = i-th transmitted), checks frame end.
    task automatic capture(input string nm, input int drop_at, output logic [9:0] fr,
                           output int fall_c);
        bit found = 0;
        bit stable = 1;
        fr = '0;
        fall_c = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        check({nm, "_start_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            fall_c = cyc;
            check({nm, "_latency"}, fall_c - last_rd_cyc, 32'd2);
            for (int i = 0; i < 10 * CPB; i++) begin
                if (i > 0) @(negedge clk);
                if (i == drop_at) enable = 1'b0;
                if (i % CPB == 0) fr[i / CPB] = tx;
                else if (tx !== fr[i / CPB]) stable = 0;
            end
            check({nm, "_bit_stable"}, {31'd0, stable}, 32'd1);
            @(negedge clk);
            check({nm, "_byte_done"}, {31'd0, byte_done}, 32'd1);
            check({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [9:0] fr;
        int fc;
        int prev_fc;
        int base;
        int k;
        bit found;
        bit tx_ok;
        logic [9:0] b2b_exp[3];

        vecs[0] = '{data: 8'h81, frame: 10'h302};
        vecs[1] = '{data: 8'h01, frame: 10'h202};
        vecs[2] = '{data: 8'h80, frame: 10'h300};
        vecs[3] = '{data: 8'hC3, frame: 10'h386};
        b2b_exp[0] = 10'h200;
        b2b_exp[1] = 10'h3FE;
        b2b_exp[2] = 10'h278;

        // Reset held 3 cycles with data waiting and enable high
        push(8'hA5);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check($sformatf("rst%0d_tx", r), {31'd0, tx}, 32'd1);
            check($sformatf("rst%0d_rd_en", r), {31'd0, fifo_rd_en}, 32'd0);
            check($sformatf("rst%0d_busy", r), {31'd0, busy}, 32'd0);
            check($sformatf("rst%0d_byte_done", r), {31'd0, byte_done}, 32'd0);
        end
        rst = 1'b0;
        capture("a5", -1, fr, fc);
        check("a5_frame", {22'd0, fr}, {22'd0, 10'h34A});
        check("a5_pops", rd_count, 32'd1);
        check("a5_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            push(vecs[v].data);
            capture($sformatf("vec%0d", v), -1, fr, fc);
            check($sformatf("vec%0d_frame", v), {22'd0, fr}, {22'd0, vecs[v].frame});
        end

        // Back-to-back frames: 40-cycle frame plus 3 idle-high cycles
        base = rd_count;
        push(8'h00); push(8'hFF); push(8'h3C);
        prev_fc = 0;
        for (int b = 0; b < 3; b++) begin
            capture($sformatf("b2b%0d", b), -1, fr, fc);
            check($sformatf("b2b%0d_frame", b), {22'd0, fr}, {22'd0, b2b_exp[b]});
            if (b > 0) check($sformatf("b2b%0d_period", b), fc - prev_fc, 32'(10 * CPB + 3));
            prev_fc = fc;
        end
        check("b2b_pops", rd_count - base, 32'd3);

        // Empty FIFO with enable high: nothing happens
        base = rd_count;
        tx_ok = 1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_ok = 0;
        end
        check("empty_no_pop", rd_count, base);
        check("empty_tx_high", {31'd0, tx_ok}, 32'd1);

        // Data waiting with enable low: no pop until enable rises
        enable = 1'b0;
        push(8'h55);
        repeat (20) @(negedge clk);
        check("gated_no_pop", rd_count, base);
        check("gated_not_empty", {31'd0, fifo_empty}, 32'd0);
        k = cyc;
        enable = 1'b1;
        capture("gate55", -1, fr, fc);
        check("gate55_start_delay", fc - k, 32'd3);
        check("gate55_frame", {22'd0, fr}, {22'd0, 10'h2AA});

        // Enable dropped during DATA of the first of two frames
        base = rd_count;
        push(8'h5A); push(8'h0F);
        capture("drop1", 14, fr, fc);
        check("drop1_frame", {22'd0, fr}, {22'd0, 10'h2B4});
        repeat (30) @(negedge clk);
        check("drop_one_pop", rd_count - base, 32'd1);
        check("drop_left_in_fifo", {31'd0, fifo_empty}, 32'd0);
        enable = 1'b1;
        capture("drop2", -1, fr, fc);
        check("drop2_frame", {22'd0, fr}, {22'd0, 10'h21E});

        // Reset during data bit 4 (frame cycles 20..23) of the first byte
        push(8'hF0); push(8'h96);
        found = 0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        check("rstmid_start_seen", {31'd0, found}, 32'd1);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_tx_high", {31'd0, tx}, 32'd1);
        check("rstmid_busy_low", {31'd0, busy}, 32'd0);
        k = cyc;
        rst = 1'b0;
        capture("rstmid", -1, fr, fc);
        check("rstmid_start_delay", fc - k, 32'd3);
        check("rstmid_frame", {22'd0, fr}, {22'd0, 10'h32C});

        repeat (5) @(negedge clk);
        check("total_pops", rd_count, 32'd13);
        check("total_byte_done", done_count, 32'd12);
        check("over_read", over_read, 32'd0);
        check("final_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
